// File: rtl/memory_dp_param_if.sv
// Signal bundle for memory_dp_param: write port, read port and clear-engine control.
// Latency: none, wires only.
// Backpressure: none; the memory drops requests while init_busy is high.
interface memory_dp_param_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic [WIDTH/8-1:0] wr_be;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               init_start;
    logic               init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, init_start,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, init_start,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/memory_dp_param.sv
// Simple dual-port flop-array RAM with byte enables, read-during-write policy and a clear engine.
// Latency: writes land at the sampling edge; read data RD_LATENCY (1 or 2) clocks after acceptance.
// Backpressure: none; while init_busy is high, read and write requests are dropped, not stalled.
module memory_dp_param #(
    parameter int DEPTH         = 8,
    parameter int WIDTH         = 32,
    parameter int RD_LATENCY    = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    memory_dp_param_if.slave bus
);
    localparam int              AW        = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
    localparam int              NB        = WIDTH / 8;
    localparam logic [AW:0]     DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "memory_dp_param: DEPTH must be >= 2");
    end
    if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "memory_dp_param: WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "memory_dp_param: RD_LATENCY must be 1 or 2");
    end

    typedef enum logic {S_IDLE = 1'b0, S_INIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             idle, wr_acc, rd_acc, rd_in_range;
    logic [WIDTH-1:0] wr_word, rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.init_start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign idle          = (state_q == S_IDLE);
    assign bus.init_busy = !idle;
    assign wr_acc        = idle && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_C);
    assign rd_acc        = idle && bus.rd_en;
    assign rd_in_range   = ({1'b0, bus.rd_addr} < DEPTH_C);

    // Merged word: enabled bytes from wr_data, the rest from the stored word.
    always_comb begin
        wr_word = mem[bus.wr_addr];
        for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) wr_word[8*i +: 8] = bus.wr_data[8*i +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (RDW_MODE != 0 && wr_acc && bus.wr_addr == bus.rd_addr) begin
                rd_word = wr_word;
            end else begin
                rd_word = mem[bus.rd_addr];
            end
        end
    end

    // The array is deliberately outside rst_n: only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.wr_addr] <= wr_word;
        end
    end

    logic             s1_vld;
    logic [WIDTH-1:0] s1_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) s1_dat <= rd_word;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic             s2_vld;
        logic [WIDTH-1:0] s2_dat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) s2_dat <= s1_dat;
            end
        end

        assign bus.rd_valid = s2_vld;
        assign bus.rd_data  = s2_dat;
    end else begin : g_lat1
        assign bus.rd_valid = s1_vld;
        assign bus.rd_data  = s1_dat;
    end
endmodule

// File: tb/tb_memory_dp_param.sv
// Bench for memory_dp_param: three parameter sets driven with shared stimulus,
// each checked every cycle against an array/timeline reference model.
module tb_memory_dp_param;
    localparam int MAXC = 4096;
    localparam int NV   = 14;
    // Per-instance parameters: a = 8/lat1/old, b = 6/lat2/new, c = 8/lat2/old/no auto-clear.
    localparam int DEP [3] = '{8, 6, 8};
    localparam int LAT [3] = '{1, 2, 2};
    localparam int RDW [3] = '{0, 1, 0};
    localparam int IOR [3] = '{1, 1, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en, rd_en, init_start;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    memory_dp_param_if #(.DEPTH(8), .WIDTH(32)) if_a ();
    memory_dp_param_if #(.DEPTH(6), .WIDTH(32)) if_b ();
    memory_dp_param_if #(.DEPTH(8), .WIDTH(32)) if_c ();

    memory_dp_param #(.DEPTH(8), .WIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    memory_dp_param #(.DEPTH(6), .WIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    memory_dp_param #(.DEPTH(8), .WIDTH(32), .RD_LATENCY(2), .RDW_MODE(0), .INIT_ON_RESET(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
    assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
    assign if_a.wr_be = wr_be;   assign if_b.wr_be = wr_be;   assign if_c.wr_be = wr_be;
    assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;   assign if_c.rd_en = rd_en;
    assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr; assign if_c.rd_addr = rd_addr;
    assign if_a.init_start = init_start;
    assign if_b.init_start = init_start;
    assign if_c.init_start = init_start;

    logic [31:0] o_data [3];
    logic        o_vld  [3];
    logic        o_busy [3];
    assign o_data[0] = if_a.rd_data; assign o_vld[0] = if_a.rd_valid; assign o_busy[0] = if_a.init_busy;
    assign o_data[1] = if_b.rd_data; assign o_vld[1] = if_b.rd_valid; assign o_busy[1] = if_b.init_busy;
    assign o_data[2] = if_c.rd_data; assign o_vld[2] = if_c.rd_valid; assign o_busy[2] = if_c.init_busy;

    // Reference model: word array, remaining clear cycles, and a timeline of expected read returns.
    logic [31:0] mem_m     [3][8];
    int          busy_left [3];
    bit          slot_v    [3][MAXC];
    logic [31:0] slot_d    [3][MAXC];
    logic [31:0] last_d    [3];
    int          cyc;
    int          n_tests, n_fail;

    bit          cap_v   [3];
    logic [31:0] cap_d   [3];
    int          cap_cyc [3];
    int          vcount  [3];
    logic [31:0] rd_or   [3];

    typedef struct packed {
        logic        wr_en;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd_en;
        logic [2:0]  ra;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
    } vec_t;
    vec_t vt [NV];

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic model_step(int k);
        logic [31:0] w;
        int          due;
        if (busy_left[k] > 0) begin
            mem_m[k][DEP[k] - busy_left[k]] = 32'h0;
            busy_left[k]--;
        end else begin
            if (rd_en) begin
                w = (int'(rd_addr) < DEP[k]) ? mem_m[k][rd_addr] : 32'h0;
                if (RDW[k] == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < DEP[k])
                    w = merge(w, wr_data, wr_be);
                due = cyc + LAT[k] - 1;
                if (due < MAXC) begin
                    slot_v[k][due] = 1'b1;
                    slot_d[k][due] = w;
                end
            end
            if (wr_en && int'(wr_addr) < DEP[k])
                mem_m[k][wr_addr] = merge(mem_m[k][wr_addr], wr_data, wr_be);
            if (init_start) busy_left[k] = DEP[k];
        end
    endtask

    task automatic check_out(int k);
        if (slot_v[k][cyc]) last_d[k] = slot_d[k][cyc];
        chk("rd_valid", k, 32'(o_vld[k]), 32'(slot_v[k][cyc]));
        chk("rd_data", k, o_data[k], last_d[k]);
        chk("init_busy", k, 32'(o_busy[k]), 32'(busy_left[k] != 0));
        if (o_vld[k] === 1'b1) begin
            cap_v[k]   = 1'b1;
            cap_d[k]   = o_data[k];
            cap_cyc[k] = cyc;
            vcount[k]++;
            rd_or[k]   = rd_or[k] | o_data[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_out(k);
        if (cyc < MAXC - 4) cyc++;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; init_start = 1'b0;
        wr_be = 4'h0; wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 32'h0;
    endtask

    task automatic assert_reset(int hold);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = (IOR[k] != 0) ? DEP[k] : 0;
            last_d[k]    = 32'h0;
            for (int c = cyc; c < cyc + 4; c++) slot_v[k][c] = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(o_vld[k]), 32'h0);
            chk("rst_data", k, o_data[k], 32'h0);
            chk("rst_busy", k, 32'(o_busy[k]), 32'(IOR[k]));
        end
        repeat (hold) tick();
        rst_n = 1'b1;
    endtask

    // Counts busy samples (taken before each edge) over n cycles; init_start lasts one cycle.
    task automatic measure_busy(int n, int ea, int eb, int ec);
        int bc [3];
        bc = '{0, 0, 0};
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) bc[k] += int'(o_busy[k] === 1'b1);
            tick();
            init_start = 1'b0;
        end
        chk("busy_len", 0, 32'(bc[0]), 32'(ea));
        chk("busy_len", 1, 32'(bc[1]), 32'(eb));
        chk("busy_len", 2, 32'(bc[2]), 32'(ec));
    endtask

    task automatic read_all();
        int v0 [3];
        for (int k = 0; k < 3; k++) begin v0[k] = vcount[k]; rd_or[k] = 32'h0; end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            tick();
        end
        rd_en = 1'b0;
        tick(); tick();
        for (int k = 0; k < 3; k++) chk("read_all_cnt", k, 32'(vcount[k] - v0[k]), 32'd8);
    endtask

    initial begin
        vt[0]  = '{1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0};
        vt[1]  = '{1'b1, 3'd3, 32'h11223344, 4'h5, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd3, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
        vt[3]  = '{1'b1, 3'd5, 32'hAAAAAAAA, 4'hF, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0};
        vt[4]  = '{1'b1, 3'd5, 32'h55555555, 4'h3, 1'b1, 3'd5, 32'hAAAAAAAA, 32'hAAAA5555, 32'hAAAAAAAA};
        vt[5]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd5, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555};
        vt[6]  = '{1'b1, 3'd7, 32'h12345678, 4'hF, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0};
        vt[7]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd7, 32'h12345678, 32'h0, 32'h12345678};
        vt[8]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd6, 32'h0, 32'h0, 32'h0};
        vt[9]  = '{1'b1, 3'd0, 32'hFFFFFFFF, 4'h0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0};
        vt[10] = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0};
        vt[11] = '{1'b1, 3'd2, 32'hCAFEF00D, 4'h8, 1'b1, 3'd2, 32'h0, 32'hCA000000, 32'h0};
        vt[12] = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 3'd2, 32'hCA000000, 32'hCA000000, 32'hCA000000};
        vt[13] = '{1'b1, 3'd4, 32'h01020304, 4'hF, 1'b1, 3'd2, 32'hCA000000, 32'hCA000000, 32'hCA000000};

        n_tests = 0; n_fail = 0; cyc = 0;
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = 0; last_d[k] = 32'h0; cap_v[k] = 1'b0; cap_d[k] = 32'h0;
            cap_cyc[k] = 0; vcount[k] = 0; rd_or[k] = 32'h0;
        end
        idle_inputs();
        #1;

        // Power-up reset; the instance without auto-clear is cleared by an explicit request.
        assert_reset(3);
        init_start = 1'b1;
        measure_busy(14, 8, 6, 8);
        read_all();
        for (int k = 0; k < 3; k++) chk("post_init_zero", k, rd_or[k], 32'h0);

        // Directed vectors: one request cycle, then idle until the read has returned.
        for (int i = 0; i < NV; i++) begin
            int          e0;
            logic [31:0] ex;
            wr_en = vt[i].wr_en; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].be;
            rd_en = vt[i].rd_en; rd_addr = vt[i].ra;
            for (int k = 0; k < 3; k++) cap_v[k] = 1'b0;
            e0 = cyc;
            tick();
            idle_inputs();
            tick(); tick();
            for (int k = 0; k < 3; k++) begin
                ex = (k == 0) ? vt[i].ea : (k == 1) ? vt[i].eb : vt[i].ec;
                chk("tbl_valid", k, 32'(cap_v[k]), 32'(vt[i].rd_en));
                if (vt[i].rd_en) begin
                    chk("tbl_data", k, cap_d[k], ex);
                    chk("tbl_latency", k, 32'(cap_cyc[k] - e0 + 1), 32'(LAT[k]));
                end
            end
        end

        // Distinct word per address, then a streaming read of every address.
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_be = 4'hF;
            wr_data = 32'h10000000 + 32'(a) * 32'h01010101;
            tick();
        end
        idle_inputs();
        read_all();

        // Clear with traffic presented while busy: no returns, writes lost.
        begin
            int v0 [3];
            init_start = 1'b1;
            tick();
            init_start = 1'b0;
            for (int k = 0; k < 3; k++) v0[k] = vcount[k];
            for (int i = 0; i < 5; i++) begin
                wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = $urandom; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 3'($urandom_range(0, 7));
                tick();
            end
            idle_inputs();
            for (int k = 0; k < 3; k++) chk("init_no_valid", k, 32'(vcount[k] - v0[k]), 32'h0);
            repeat (4) tick();
            read_all();
            for (int k = 0; k < 3; k++) chk("init_cleared", k, rd_or[k], 32'h0);
        end

        // Reset in the middle of a clear.
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_be = 4'hF; wr_data = 32'hA5A50000 | 32'(a);
            tick();
        end
        idle_inputs();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick(); tick();
        assert_reset(2);
        measure_busy(12, 8, 6, 0);
        read_all();

        // Random traffic with biased address collisions and occasional clears.
        for (int i = 0; i < 800; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            init_start = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
